// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the multi-channel memory port arbiter: FSM encoding,
// arbitration mode codes and the channel-index width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Never returns less than 1 so a 1-entry range still gets a real bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle of the arbiter. The master view is the
// requesters together with the memory model; the slave view is the arbiter.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_CH    = 2
);
    logic [NUM_CH-1:0]           req_read;
    logic [NUM_CH-1:0]           req_write;
    logic [NUM_CH*WORD_SIZE-1:0] req_address;
    logic [NUM_CH*WORD_SIZE-1:0] req_wdata;
    logic [NUM_CH-1:0]           done;
    logic [NUM_CH*WORD_SIZE-1:0] rdata;

    logic                        m_readM;
    logic                        m_writeM;
    logic [WORD_SIZE-1:0]        m_address;
    logic [WORD_SIZE-1:0]        m_wdata;
    logic [WORD_SIZE-1:0]        m_rdata;

    modport master (
        output req_read, req_write, req_address, req_wdata, m_rdata,
        input  done, rdata, m_readM, m_writeM, m_address, m_wdata
    );

    modport slave (
        input  req_read, req_write, req_address, req_wdata, m_rdata,
        output done, rdata, m_readM, m_writeM, m_address, m_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_picker.sv
// Combinational grant selection: fixed priority (lowest index) or round-robin
// starting one past the pointer.
module arb_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              rr_mode,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    logic [IDX_W-1:0] cand;

    function automatic logic [IDX_W-1:0] candidate(input logic [IDX_W-1:0] p,
                                                    input int offset,
                                                    input logic rr);
        int pos;
        pos = rr ? (int'(p) + 1 + offset) % NUM_CH : offset;
        return IDX_W'(pos);
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop
        // leaves a value held, which would infer a latch.
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int offset = 0; offset < NUM_CH; offset++) begin
            cand = candidate(ptr, offset, rr_mode);
            if (!grant_valid && req[cand]) begin
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges NUM_CH requester channels onto one fixed-latency memory port, one
// transaction in flight at a time, with registered strobes and responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int NUM_CH      = 2,
    parameter int MEM_LATENCY = 2,
    parameter int ARB_MODE    = ARB_FIXED
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] access_count
);

    localparam int IDX_W = clog2(NUM_CH);
    localparam int CNT_W = clog2(MEM_LATENCY);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_CH - 1);

    state_t               state;
    op_t                  cur_op;
    logic [IDX_W-1:0]     cur_ch;
    logic [IDX_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     lat_cnt;
    logic                 read_q;
    logic                 write_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [NUM_CH-1:0]    done_q;
    logic [WORD_SIZE-1:0] rdata_q  [NUM_CH];
    logic [WORD_SIZE-1:0] ch_addr  [NUM_CH];
    logic [WORD_SIZE-1:0] ch_wdata [NUM_CH];

    logic [NUM_CH-1:0]    req_any;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;

    assign req_any = bus.req_read | bus.req_write;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_addr[k]  = bus.req_address[k*WORD_SIZE +: WORD_SIZE];
        assign ch_wdata[k] = bus.req_wdata[k*WORD_SIZE +: WORD_SIZE];
        assign bus.rdata[k*WORD_SIZE +: WORD_SIZE] = rdata_q[k];
    end

    arb_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req         (req_any),
        .ptr         (rr_ptr),
        .rr_mode     (ARB_MODE == ARB_RR),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // The address/wdata registers double as the grant-time latches, so later
    // changes on the request inputs cannot reach the memory port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cur_op       <= OP_READ;
            cur_ch       <= '0;
            rr_ptr       <= PTR_INIT;
            lat_cnt      <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= '0;
            access_count <= '0;
            // NOTE: rdata_q is a handful of flops visible on the ports, not a
            // RAM, so it is cleared like any other state register.
            for (int k = 0; k < NUM_CH; k++) begin
                rdata_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge values of state, counters and latches.
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cur_ch  <= grant_idx;
                        rr_ptr  <= grant_idx;
                        cur_op  <= bus.req_write[grant_idx] ? OP_WRITE : OP_READ;
                        write_q <= bus.req_write[grant_idx];
                        read_q  <= !bus.req_write[grant_idx];
                        addr_q  <= ch_addr[grant_idx];
                        wdata_q <= ch_wdata[grant_idx];
                        lat_cnt <= LAT_LOAD;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (lat_cnt == '0) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        if (cur_op == OP_READ) begin
                            rdata_q[cur_ch] <= bus.m_rdata;
                        end
                        done_q[cur_ch] <= 1'b1;
                        access_count   <= access_count + 1'b1;
                        state          <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_readM   = read_q;
    assign bus.m_writeM  = write_q;
    assign bus.m_address = addr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.done      = done_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three configurations (2-ch fixed,
// 4-ch round-robin, 4-bit counter) driven and sampled on the falling edge.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter_if #(.WORD_SIZE(16), .NUM_CH(2)) bus0 ();
    mem_port_arbiter_if #(.WORD_SIZE(16), .NUM_CH(4)) bus1 ();
    mem_port_arbiter_if #(.WORD_SIZE(4),  .NUM_CH(2)) bus2 ();

    logic        busy0, busy1, busy2;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;
    logic [15:0] last_wr_addr, last_wr_data;

    function automatic logic [15:0] mem0_read(input logic [15:0] a);
        case (a)
            16'h0040: return 16'hBEEF;
            16'h0020: return 16'h5A5A;
            16'h0030: return 16'h7777;
            default:  return a ^ 16'hA5A5;
        endcase
    endfunction

    assign bus0.m_rdata = mem0_read(bus0.m_address);
    assign bus1.m_rdata = bus1.m_address ^ 16'hA5A5;
    assign bus2.m_rdata = 4'h3;

    always @(posedge clk) begin
        if (bus0.m_writeM) begin
            last_wr_addr <= bus0.m_address;
            last_wr_data <= bus0.m_wdata;
        end
    end

    mem_port_arbiter #(.WORD_SIZE(16), .NUM_CH(2), .MEM_LATENCY(2), .ARB_MODE(0)) u_fixed (
        .clk(clk), .reset(rst0), .bus(bus0), .busy(busy0), .access_count(cnt0));
    mem_port_arbiter #(.WORD_SIZE(16), .NUM_CH(4), .MEM_LATENCY(2), .ARB_MODE(1)) u_rr (
        .clk(clk), .reset(rst1), .bus(bus1), .busy(busy1), .access_count(cnt1));
    mem_port_arbiter #(.WORD_SIZE(4), .NUM_CH(2), .MEM_LATENCY(1), .ARB_MODE(0)) u_wrap (
        .clk(clk), .reset(rst2), .bus(bus2), .busy(busy2), .access_count(cnt2));

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy0, bus0.m_readM, bus0.m_writeM, bus0.done, cnt0, bus0.m_address} !== 37'd0) begin
            n_fail++; $display("FAIL reset_u0_outputs: got %h expected 0",
                {busy0, bus0.m_readM, bus0.m_writeM, bus0.done, cnt0, bus0.m_address});
        end
        n_checks++;
        if (bus0.rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_u0_rdata: got %h expected 0", bus0.rdata);
        end
        n_checks++;
        if ({busy1, bus1.m_readM, bus1.m_writeM, bus1.done, cnt1} !== 23'd0) begin
            n_fail++; $display("FAIL reset_u1_outputs: got %h expected 0",
                {busy1, bus1.m_readM, bus1.m_writeM, bus1.done, cnt1});
        end
        n_checks++;
        if ({busy2, bus2.done, cnt2, bus2.rdata} !== 15'd0) begin
            n_fail++; $display("FAIL reset_u2_outputs: got %h expected 0",
                {busy2, bus2.done, cnt2, bus2.rdata});
        end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy0, busy1, busy2} !== 3'b000) begin
            n_fail++; $display("FAIL idle_no_request: busy got %b expected 000", {busy0, busy1, busy2});
        end
    endtask

    task automatic test_single_read();
        bus0.req_address[31:16] = 16'h0040;
        bus0.req_read[1] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c < 3) begin
                n_checks++;
                if ({bus0.m_readM, bus0.m_writeM, busy0, bus0.m_address, bus0.done} !== {3'b101, 16'h0040, 2'b00}) begin
                    n_fail++; $display("FAIL single_read_busy%0d: got %h expected %h", c,
                        {bus0.m_readM, bus0.m_writeM, busy0, bus0.m_address, bus0.done}, {3'b101, 16'h0040, 2'b00});
                end
            end else begin
                n_checks++;
                if ({bus0.done, bus0.m_readM, bus0.m_writeM, busy0} !== 5'b10001) begin
                    n_fail++; $display("FAIL single_read_resp: got %b expected 10001",
                        {bus0.done, bus0.m_readM, bus0.m_writeM, busy0});
                end
                n_checks++;
                if (bus0.rdata[31:16] !== 16'hBEEF) begin
                    n_fail++; $display("FAIL single_read_rdata: got %h expected beef", bus0.rdata[31:16]);
                end
                n_checks++;
                if (cnt0 !== 16'd1) begin
                    n_fail++; $display("FAIL single_read_count: got %0d expected 1", cnt0);
                end
            end
        end
        bus0.req_read[1] = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy0, bus0.done, bus0.rdata[31:16]} !== {3'b000, 16'hBEEF}) begin
            n_fail++; $display("FAIL single_read_after: got %h expected %h",
                {busy0, bus0.done, bus0.rdata[31:16]}, {3'b000, 16'hBEEF});
        end
    endtask

    task automatic test_fixed_priority();
        int d0 = -1;
        int d1 = -1;
        bus0.req_address = {16'h0020, 16'h0010};
        bus0.req_wdata   = {16'h0000, 16'h1234};
        bus0.req_write   = 2'b01;
        bus0.req_read    = 2'b10;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if ({bus0.m_writeM, bus0.m_readM, bus0.m_address, bus0.m_wdata} !== {2'b10, 16'h0010, 16'h1234}) begin
                    n_fail++; $display("FAIL prio_first_grant: got %h expected %h",
                        {bus0.m_writeM, bus0.m_readM, bus0.m_address, bus0.m_wdata}, {2'b10, 16'h0010, 16'h1234});
                end
            end
            n_checks++;
            if (bus0.m_readM && bus0.m_writeM) begin
                n_fail++; $display("FAIL prio_strobes_exclusive: cycle %0d got both high expected at most one", c);
            end
            if (bus0.done[0]) begin d0 = c; bus0.req_write[0] = 1'b0; end
            if (bus0.done[1]) begin d1 = c; bus0.req_read[1] = 1'b0; end
            if (d0 >= 0 && d1 >= 0) break;
        end
        bus0.req_write = '0; bus0.req_read = '0;
        n_checks++;
        if (d0 != 3 || d1 != 7) begin
            n_fail++; $display("FAIL prio_done_order: got done0@%0d done1@%0d expected 3 and 7", d0, d1);
        end
        n_checks++;
        if (bus0.rdata !== {16'h5A5A, 16'h0000}) begin
            n_fail++; $display("FAIL prio_rdata: got %h expected 5a5a0000", bus0.rdata);
        end
        n_checks++;
        if ({last_wr_addr, last_wr_data} !== {16'h0010, 16'h1234}) begin
            n_fail++; $display("FAIL prio_mem_write: got %h expected 00101234", {last_wr_addr, last_wr_data});
        end
        n_checks++;
        if (cnt0 !== 16'd3) begin
            n_fail++; $display("FAIL prio_count: got %0d expected 3", cnt0);
        end
        @(negedge clk);
    endtask

    task automatic test_read_write_same();
        bus0.req_address[15:0] = 16'h0030;
        bus0.req_wdata[15:0]   = 16'h00AA;
        bus0.req_read[0]  = 1'b1;
        bus0.req_write[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c < 3) begin
                n_checks++;
                if ({bus0.m_writeM, bus0.m_readM, bus0.m_address} !== {2'b10, 16'h0030}) begin
                    n_fail++; $display("FAIL rw_write_wins%0d: got %h expected %h", c,
                        {bus0.m_writeM, bus0.m_readM, bus0.m_address}, {2'b10, 16'h0030});
                end
            end else begin
                n_checks++;
                if ({bus0.done, bus0.rdata[15:0]} !== {2'b01, 16'h0000}) begin
                    n_fail++; $display("FAIL rw_resp: got %h expected %h", {bus0.done, bus0.rdata[15:0]}, {2'b01, 16'h0000});
                end
            end
        end
        bus0.req_read[0] = 1'b0; bus0.req_write[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({last_wr_addr, last_wr_data, cnt0} !== {16'h0030, 16'h00AA, 16'd4}) begin
            n_fail++; $display("FAIL rw_mem_write: got %h expected %h",
                {last_wr_addr, last_wr_data, cnt0}, {16'h0030, 16'h00AA, 16'd4});
        end
    endtask

    task automatic test_reset_mid_busy();
        int dc = -1;
        bus0.req_address[31:16] = 16'h0040;
        bus0.req_read[1] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy0, bus0.m_readM} !== 2'b11) begin
            n_fail++; $display("FAIL abort_busy_entry: got %b expected 11", {busy0, bus0.m_readM});
        end
        rst0 = 1'b1;
        bus0.req_read[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy0, bus0.m_readM, bus0.m_writeM, bus0.done, cnt0, bus0.rdata} !== 52'd0) begin
            n_fail++; $display("FAIL abort_cleared: got %h expected 0",
                {busy0, bus0.m_readM, bus0.m_writeM, bus0.done, cnt0, bus0.rdata});
        end
        rst0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy0, bus0.done} !== 3'b000) begin
            n_fail++; $display("FAIL abort_no_done: got %b expected 000", {busy0, bus0.done});
        end
        bus0.req_address[15:0] = 16'h0020;
        bus0.req_read[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus0.done[0]) begin dc = c; break; end
        end
        bus0.req_read[0] = 1'b0;
        n_checks++;
        if (dc != 3) begin
            n_fail++; $display("FAIL abort_fresh_latency: got done@%0d expected 3", dc);
        end
        n_checks++;
        if ({bus0.rdata[15:0], cnt0} !== {16'h5A5A, 16'd1}) begin
            n_fail++; $display("FAIL abort_fresh_result: got %h expected 5a5a0001", {bus0.rdata[15:0], cnt0});
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int order [5];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int n_done = 0;
        int last_c = -1;
        for (int k = 0; k < 4; k++) begin
            bus1.req_address[k*16 +: 16] = 16'(16'h0100 + k);
        end
        bus1.req_read = 4'hF;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus1.m_readM && bus1.m_writeM) begin
                n_fail++; $display("FAIL rr_strobes_exclusive: cycle %0d got both high expected at most one", c);
            end
            if (bus1.done != 4'b0000) begin
                n_checks++;
                if ($countones(bus1.done) != 1) begin
                    n_fail++; $display("FAIL rr_done_onehot: got %b expected one bit", bus1.done);
                end
                for (int k = 0; k < 4; k++) begin
                    if (bus1.done[k]) order[n_done] = k;
                end
                n_done++;
                last_c = c;
                if (n_done == 5) break;
            end
        end
        bus1.req_read = 4'h0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= n_done || order[i] != exp_order[i]) begin
                n_fail++; $display("FAIL rr_grant_order[%0d]: got %0d expected %0d",
                    i, (i < n_done) ? order[i] : -1, exp_order[i]);
            end
        end
        n_checks++;
        if (last_c != 19 || cnt1 !== 16'd5) begin
            n_fail++; $display("FAIL rr_timing_count: got done5@%0d count %0d expected 19 and 5", last_c, cnt1);
        end
        n_checks++;
        if (bus1.rdata[47:32] !== (16'h0102 ^ 16'hA5A5)) begin
            n_fail++; $display("FAIL rr_rdata2: got %h expected %h", bus1.rdata[47:32], 16'h0102 ^ 16'hA5A5);
        end
        @(negedge clk);
    endtask

    task automatic test_counter_wrap();
        int n_done = 0;
        int last_c = -1;
        bus2.req_address = 8'h05;
        bus2.req_read    = 2'b01;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus2.done[0]) begin
                n_done++;
                last_c = c;
                if (n_done == 15) begin
                    n_checks++;
                    if (cnt2 !== 4'd15) begin
                        n_fail++; $display("FAIL wrap_count15: got %0d expected 15", cnt2);
                    end
                end
                if (n_done == 16) break;
            end
        end
        bus2.req_read = 2'b00;
        n_checks++;
        if (n_done != 16 || last_c != 47) begin
            n_fail++; $display("FAIL wrap_throughput: got %0d dones last@%0d expected 16 last@47", n_done, last_c);
        end
        n_checks++;
        if ({cnt2, bus2.rdata} !== {4'd0, 4'h0, 4'h3}) begin
            n_fail++; $display("FAIL wrap_count_rdata: got %h expected 003", {cnt2, bus2.rdata});
        end
    endtask

    initial begin
        bus0.req_read = '0; bus0.req_write = '0; bus0.req_address = '0; bus0.req_wdata = '0;
        bus1.req_read = '0; bus1.req_write = '0; bus1.req_address = '0; bus1.req_wdata = '0;
        bus2.req_read = '0; bus2.req_write = '0; bus2.req_address = '0; bus2.req_wdata = '0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_read_write_same();
        test_reset_mid_busy();
        test_round_robin();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised multi-channel memory port arbiter; successor to the CPU's fixed split instruction/data memory ports.
- Merges NUM_CH requester channels onto one fixed-latency memory port; channel 0 is typically data, channel 1 instruction.
- Sits between CPU/DMA requesters and the unified memory model. One transaction in flight at a time.

Parameters:
- WORD_SIZE, 16, data and address width.
- NUM_CH, 2, number of requester channels; legal range 2..8.
- MEM_LATENCY, 2, cycles the memory needs per access; legal range 1..15.
- ARB_MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_read  in  NUM_CH  per-channel read request, level.
- req_write  in  NUM_CH  per-channel write request, level.
- req_address  in  NUM_CH*WORD_SIZE  flattened addresses; channel k occupies bits [k*WORD_SIZE +: WORD_SIZE].
- req_wdata  in  NUM_CH*WORD_SIZE  flattened write data, same packing.
- done  out  NUM_CH  one-cycle completion pulse per channel.
- rdata  out  NUM_CH*WORD_SIZE  per-channel registered read data.
- m_readM  out  1  memory read strobe.
- m_writeM  out  1  memory write strobe.
- m_address  out  WORD_SIZE  memory address.
- m_wdata  out  WORD_SIZE  memory write data.
- m_rdata  in  WORD_SIZE  memory read data.
- busy  out  1  high while a transaction is in flight (BUSY or RESP).
- access_count  out  WORD_SIZE  number of completed transactions; wraps.

Behaviour:
- Reset: state=IDLE; all outputs 0; rdata all 0; round-robin pointer = NUM_CH-1, so channel 0 has first priority.
- Reset asserted mid-transaction aborts it: no done pulse; strobes drop the cycle after reset is sampled.
- FSM states:
  - IDLE -> BUSY when any req_read|req_write bit is high.
  - BUSY -> RESP after MEM_LATENCY cycles.
  - RESP -> IDLE unconditionally.
- Grant (IDLE, cycle t):
  - Select the channel, then latch channel index, op, address and wdata.
  - Latched values hold stable through BUSY; later changes on the request inputs are ignored.
  - If a channel asserts both read and write, write takes precedence.
- BUSY (cycles t+1 .. t+MEM_LATENCY):
  - m_readM or m_writeM is high for exactly MEM_LATENCY cycles; m_address/m_wdata driven from latches.
  - A down-counter loads MEM_LATENCY-1 on entry and reaches 0 in the last BUSY cycle.
  - On a read, m_rdata is sampled at the end of the last BUSY cycle.
- RESP (cycle t+MEM_LATENCY+1):
  - done[ch]=1 for one cycle only; strobes 0.
  - rdata[ch] updates on a read; it holds until that channel's next read completes. Other channels' rdata are untouched.
  - access_count increments here, wrapping from 2^WORD_SIZE-1 to 0.
- Back-to-back: at least one IDLE cycle between transactions. Minimum period is MEM_LATENCY+2 cycles.
- Requester protocol:
  - Hold the request until done is seen.
  - Deassert (or re-issue) in the cycle after done. The arbiter samples in the IDLE cycle following RESP, so a held request is not double-served.
  - A request withdrawn during BUSY still completes and still pulses done.
- Arbitration:
  - Fixed mode: lowest asserted index wins.
  - Round-robin: search starts at pointer+1 modulo NUM_CH; pointer updates to the granted index at grant.
  - No request in IDLE: stay IDLE; pointer unchanged.
- Memory strobes are never both high. busy = (state != IDLE).

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2;
  - ARB_FIXED=0 and ARB_RR=1;
  - the channel-index width function clog2.
- One sub-module, arb_picker: combinational request vector plus pointer plus mode in, granted index plus valid out. This keeps the FSM/latch logic in mem_port_arbiter separately testable.

Test Plan:
- Single read: ch1 reads addr 0x0040, memory returns 0xBEEF, MEM_LATENCY=2 -> m_readM high for 2 cycles with m_address=0x0040; done[1] 3 cycles after grant; rdata[1]=0xBEEF; access_count=1.
- Fixed priority conflict (ARB_MODE=0): ch0 write 0x1234 to 0x0010 and ch1 read 0x0020 raised in the same cycle -> ch0 served first, then ch1; done[0] precedes done[1] by MEM_LATENCY+2 cycles.
- Round-robin fairness (ARB_MODE=1, NUM_CH=4): all four channels request continuously -> grant order 0,1,2,3,0; no channel is served twice before the others are served.
- Read+write on one channel: ch0 with both read and write set, wdata 0x00AA -> m_writeM only, m_readM stays 0; rdata[0] unchanged.
- Reset mid-BUSY: assert reset in the 1st BUSY cycle -> next cycle strobes=0, busy=0, no done pulse, access_count=0; a fresh request afterwards completes normally.
- Counter wrap (WORD_SIZE=4): run 16 transactions -> access_count returns to 0.
